seg7_scan4: RTL and testbench

- Downstream display stage for the debounced key counter: takes four 4-bit digit values and drives a 4-digit multiplexed common-anode seven-segment display.
- Display data is double-buffered: new data is latched on an update strobe and only applied at a frame boundary, so the display never shows a mix of old and new digits.
- Sits after the counter/carry stage; the counter's Q/CO and higher digits feed din.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_dec.sv | 14 +
 rtl/seg7_scan4.sv | 142 ++++++++++++++
 tb/tb_seg7_scan4.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: segment patterns,
// blank codes and the digit count.
package seg7_pkg;

  localparam int N_DIG = 4;

  // Segments are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  // Digit enables are active-low, so all-ones selects no digit.
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Hex glyphs 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational 4-bit hex digit to active-low seven-segment pattern.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup covering the full 0-F range.
  always_comb begin
    seg = SEG_LUT[digit];
  end

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed common-anode seven-segment driver with a
// double-buffered display register that only changes at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      din,
  input  logic [3:0]       dp_in,
  input  logic             upd,
  input  logic             blank,
  output logic [N_DIG-1:0] dig_sel,
  output logic [6:0]       codeout,
  output logic             dp_n,
  output logic             frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      pend_din_q, pend_din_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_flag_q, pend_flag_d;
  logic [15:0]      act_din_q, act_din_d;
  logic [3:0]       act_dp_q, act_dp_d;
  logic [N_DIG-1:0] dig_sel_q, dig_sel_d;
  logic [6:0]       code_q, code_d;
  logic             dp_n_q, dp_n_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_seg;
  logic             cur_dp;
  logic             lz_blank;

  // Slot timing and buffer hand-over: pending moves to active only at the
  // end of slot 3, and a strobe on that same edge refills pending afterwards.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    presc_d     = presc_q + CNT_W'(1);
    idx_d       = idx_q;
    pend_din_d  = pend_din_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    act_din_d   = act_din_q;
    act_dp_d    = act_dp_q;

    tick     = (presc_q == CNT_W'(SCAN_DIV - 1));
    boundary = tick && (idx_q == 2'd3);

    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end

    if (boundary && pend_flag_q) begin
      act_din_d   = pend_din_q;
      act_dp_d    = pend_dp_q;
      pend_flag_d = 1'b0;
    end

    if (upd) begin
      pend_din_d  = din;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end

    frame_done_d = boundary;
  end

  // Select the digit that will be shown after this edge, so the registered
  // outputs line up with the new slot index.
  always_comb begin
    cur_digit = 4'(act_din_d >> {idx_d, 2'b00});
    cur_dp    = act_dp_d[idx_d];
`ifdef SEG7_LZ_BLANK_EN
    // Digit k is blank when it and every digit above it are zero; digit 0 never is.
    lz_blank  = (idx_d != 2'd0) && ((act_din_d >> {idx_d, 2'b00}) == 16'd0);
`else
    lz_blank  = 1'b0;
`endif
  end

  seg7_hex_dec u_dec (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  // Output pattern for the next slot, forced dark while blank is held.
  always_comb begin
    dig_sel_d = DIG_OFF;
    code_d    = SEG_OFF;
    dp_n_d    = 1'b1;
    if (!blank) begin
      dig_sel_d = ~(N_DIG'(1) << idx_d);
      code_d    = lz_blank ? SEG_OFF : cur_seg;
      dp_n_d    = ~cur_dp;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      pend_din_q   <= 16'd0;
      pend_dp_q    <= 4'd0;
      pend_flag_q  <= 1'b0;
      act_din_q    <= 16'd0;
      act_dp_q     <= 4'd0;
      dig_sel_q    <= DIG_OFF;
      code_q       <= SEG_OFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_din_q   <= pend_din_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      act_din_q    <= act_din_d;
      act_dp_q     <= act_dp_d;
      dig_sel_q    <= dig_sel_d;
      code_q       <= code_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dig_sel    = dig_sel_q;
  assign codeout    = code_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Self-checking bench for seg7_scan4 with SCAN_DIV=4. The reference model
// derives slot and frame position from the number of clock edges since reset
// and keeps the display buffers as plain variables. Define SEG7_LZ_BLANK_EN
// for both bench and RTL to check leading-zero blanking.
module tb_seg7_scan4;

  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        upd;
  logic        blank;
  logic [3:0]  dig_sel;
  logic [6:0]  codeout;
  logic        dp_n;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // Bench-side glyph table, written out from the display glyph definitions.
  logic [6:0] glyph [16];

  // Reference model state.
  int          m_cycle;
  logic [15:0] m_act_din, m_pend_din;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_flag;
  logic        m_blank;
  logic        m_frame;

  seg7_scan4 #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dp_in      (dp_in),
    .upd        (upd),
    .blank      (blank),
    .dig_sel    (dig_sel),
    .codeout    (codeout),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_cycle);
    end
  endtask

  task automatic model_reset();
    m_cycle    = 0;
    m_act_din  = 16'd0;
    m_act_dp   = 4'd0;
    m_pend_din = 16'd0;
    m_pend_dp  = 4'd0;
    m_flag     = 1'b0;
    m_blank    = 1'b0;
    m_frame    = 1'b0;
  endtask

  // Compare all outputs against what the model says the display shows now.
  task automatic compare_outputs(input string tag);
    int          slot;
    logic [15:0] upper;
    logic [6:0]  exp_code;
    logic [3:0]  exp_sel;
    logic        exp_dp;
    slot  = (m_cycle / SD) % 4;
    upper = m_act_din >> (4 * slot);
    if (m_blank) begin
      exp_sel  = 4'hF;
      exp_code = 7'h7F;
      exp_dp   = 1'b1;
    end else begin
      exp_sel  = ~(4'b0001 << slot);
      exp_code = glyph[upper[3:0]];
`ifdef SEG7_LZ_BLANK_EN
      if (slot != 0 && upper == 16'd0) exp_code = 7'h7F;
`endif
      exp_dp   = ~m_act_dp[slot];
    end
    check({tag, ".dig_sel"}, 32'(dig_sel), 32'(exp_sel));
    check({tag, ".codeout"}, 32'(codeout), 32'(exp_code));
    check({tag, ".dp_n"}, 32'(dp_n), 32'(exp_dp));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(m_frame));
  endtask

  // One clock: drive inputs, advance the model across the edge, check after it.
  task automatic step(input string tag, input logic u, input logic [15:0] d,
                      input logic [3:0] p, input logic b);
    upd   = u;
    din   = d;
    dp_in = p;
    blank = b;
    @(posedge clk);
    // The last edge of each frame hands pending over before any new strobe lands.
    m_frame = ((m_cycle % FRAME) == FRAME - 1);
    if (m_frame && m_flag) begin
      m_act_din = m_pend_din;
      m_act_dp  = m_pend_dp;
      m_flag    = 1'b0;
    end
    if (u) begin
      m_pend_din = d;
      m_pend_dp  = p;
      m_flag     = 1'b1;
    end
    m_blank = b;
    m_cycle++;
    #1;
    compare_outputs(tag);
    upd = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, din, dp_in, 1'b0);
  endtask

  // Idle until the next edge is the given position within the frame.
  task automatic align(input int pos);
    for (int i = 0; i < FRAME && (m_cycle % FRAME) != pos; i++)
      step("align", 1'b0, din, dp_in, 1'b0);
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    din   = 16'd0;
    dp_in = 4'd0;
    upd   = 1'b0;
    blank = 1'b0;
    reset = 1'b0;
    model_reset();

    // Reset values.
    #1 reset = 1'b1;
    #3;
    check("rst.dig_sel", 32'(dig_sel), 32'h0000_000F);
    check("rst.codeout", 32'(codeout), 32'h0000_007F);
    check("rst.dp_n", 32'(dp_n), 32'h1);
    check("rst.frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle scanning: all zeros, frame_done every 16 cycles.
    idle("idle", 2 * FRAME);

    // Mid-frame update only shows from the next slot 0.
    align(5);
    step("upd1234", 1'b1, 16'h1234, 4'b0000, 1'b0);
    idle("run1234", 2 * FRAME);

    // Two updates before the boundary: the later one wins.
    align(3);
    step("upd1111", 1'b1, 16'h1111, 4'b0001, 1'b0);
    idle("gap", 3);
    step("upd2222", 1'b1, 16'h2222, 4'b0100, 1'b0);
    idle("run2222", 2 * FRAME);

    // Update exactly on the boundary-tick cycle waits a full frame.
    align(FRAME - 1);
    step("updABCD", 1'b1, 16'hABCD, 4'b1010, 1'b0);
    idle("runABCD", 2 * FRAME);

    // Boundary update arriving while a pending value is already queued.
    align(9);
    step("updq1", 1'b1, 16'h5678, 4'b0011, 1'b0);
    align(FRAME - 1);
    step("updq2", 1'b1, 16'h9F0E, 4'b1100, 1'b0);
    idle("runq", 2 * FRAME);

    // Blank during slot 2, then release.
    align(2 * SD);
    for (int i = 0; i < 10; i++) step("blank", 1'b0, din, dp_in, 1'b1);
    idle("unblank", FRAME);

    // Leading zeros.
    step("upd0050", 1'b1, 16'h0050, 4'b0000, 1'b0);
    idle("run0050", 2 * FRAME);
    step("upd0000", 1'b1, 16'h0000, 4'b0101, 1'b0);
    idle("run0000", 2 * FRAME);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
           ($urandom_range(0, 11) == 0));
    end
    idle("settle", 2 * FRAME);

    // Asynchronous reset mid-frame with an update pending.
    align(6);
    step("updpre", 1'b1, 16'h8888, 4'b1111, 1'b0);
    idle("pre", 2);
    #2 reset = 1'b1;
    #1;
    check("arst.dig_sel", 32'(dig_sel), 32'h0000_000F);
    check("arst.codeout", 32'(codeout), 32'h0000_007F);
    check("arst.dp_n", 32'(dp_n), 32'h1);
    check("arst.frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    idle("post", 2 * FRAME + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
